// File: rtl/pdm_mic_frontend.sv
// PDM microphone front-end: mic clock generation, L/R sampling, per-channel sinc3 CIC, scaled PCM out.
// Optional build macro PDM_DC_BLOCK_EN adds a per-channel DC-removal stage after saturation.
module pdm_mic_frontend #(
  parameter int CLK_DIV = 16,
  parameter int DEC     = 64,
  parameter int OUT_W   = 16,
  parameter int ACC_W   = 3*$clog2(DEC)+2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    pdm_i,
  output logic                    mic_clk_o,
  output logic                    sel_lr_o,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    ch_o,
  output logic                    valid_o
);

  localparam int LOG2_DEC = $clog2(DEC);
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int SHIFT    = 3*LOG2_DEC - (OUT_W-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [DIV_W-1:0]    div;
  logic                run;
  logic [1:0]          mode_q;
  logic [LOG2_DEC-1:0] dec_cnt;
  logic [1:0]          warm;
  logic                pend_l, pend_r, pend_out;

  logic signed [ACC_W-1:0] int_l [3];
  logic signed [ACC_W-1:0] int_r [3];
  logic signed [ACC_W-1:0] dly_l [3];
  logic signed [ACC_W-1:0] dly_r [3];

  logic                    start, tick_l, tick_r, boundary, mode_chg, clr;
  logic                    act_l, act_r, sel_r, emit;
  logic signed [ACC_W-1:0] smp, il1, il2, il3, ir1, ir2, ir3;
  logic signed [ACC_W-1:0] cx, c1, c2, c3, scaled;
  logic signed [OUT_W-1:0] sat_d;

  assign start    = en & ~run;
  assign tick_l   = run & en & (div == DIV_W'(CLK_DIV/2-1));
  assign tick_r   = run & en & (div == DIV_W'(CLK_DIV-1));
  assign boundary = tick_r & (dec_cnt == '1);
  assign mode_chg = boundary & (mode != mode_q);
  assign clr      = sys_rst | ~en | mode_chg;
  assign act_l    = mode_q[1] | ~mode_q[0];
  assign act_r    = mode_q[1] | mode_q[0];
  assign sel_r    = ~pend_l;
  assign emit     = (pend_l | pend_r) & pend_out;

  assign mic_clk_o = run & (div < DIV_W'(CLK_DIV/2));
  assign sel_lr_o  = ~mode_q[1] & mode_q[0];

  always_comb begin
    smp = pdm_i ? ACC_W'(1) : '1;
    il1 = int_l[0] + smp;
    il2 = int_l[1] + il1;
    il3 = int_l[2] + il2;
    ir1 = int_r[0] + smp;
    ir2 = int_r[1] + ir1;
    ir3 = int_r[2] + ir2;
  end

  // One comb datapath shared by both channels: left in the first cycle after a boundary, right after it.
  always_comb begin
    cx     = sel_r ? int_r[2] : int_l[2];
    c1     = cx - (sel_r ? dly_r[0] : dly_l[0]);
    c2     = c1 - (sel_r ? dly_r[1] : dly_l[1]);
    c3     = c2 - (sel_r ? dly_r[2] : dly_l[2]);
    scaled = c3 >>> SHIFT;
    sat_d  = scaled[OUT_W-1:0];
    if (scaled > SAT_MAX)      sat_d = SAT_MAX[OUT_W-1:0];
    else if (scaled < SAT_MIN) sat_d = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      run    <= 1'b0;
      div    <= '0;
      mode_q <= '0;
    end else begin
      run <= en;
      if (!en || !run)                     div <= '0;
      else if (div == DIV_W'(CLK_DIV-1))   div <= '0;
      else                                 div <= div + 1'b1;
      if (start || boundary) mode_q <= mode;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        int_l[i] <= '0;
        int_r[i] <= '0;
        dly_l[i] <= '0;
        dly_r[i] <= '0;
      end
      dec_cnt  <= '0;
      warm     <= '0;
      pend_l   <= 1'b0;
      pend_r   <= 1'b0;
      pend_out <= 1'b0;
    end else begin
      if (tick_l && act_l) begin
        int_l[0] <= il1;
        int_l[1] <= il2;
        int_l[2] <= il3;
      end
      if (tick_r && act_r) begin
        int_r[0] <= ir1;
        int_r[1] <= ir2;
        int_r[2] <= ir3;
      end
      if (tick_r) dec_cnt <= dec_cnt + 1'b1;
      if (boundary) begin
        pend_l   <= act_l;
        pend_r   <= act_r;
        pend_out <= (warm == 2'd3);
        if (warm != 2'd3) warm <= warm + 2'd1;
      end else if (pend_l) begin
        pend_l <= 1'b0;
      end else if (pend_r) begin
        pend_r <= 1'b0;
      end
      // Combs advance during warm-up too so their history is primed once output starts.
      if (pend_l || pend_r) begin
        if (sel_r) begin
          dly_r[0] <= cx;
          dly_r[1] <= c1;
          dly_r[2] <= c2;
        end else begin
          dly_l[0] <= cx;
          dly_l[1] <= c1;
          dly_l[2] <= c2;
        end
      end
    end
  end

`ifdef PDM_DC_BLOCK_EN
  localparam logic signed [OUT_W+1:0] DC_MAX = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W+1:0] DC_MIN = ~DC_MAX;

  logic                    s_v, s_ch;
  logic signed [OUT_W-1:0] s_d, dc_out;
  logic signed [OUT_W-1:0] dc_x [2];
  logic signed [OUT_W-1:0] dc_y [2];
  logic signed [OUT_W+1:0] dc_sum;

  always_comb begin
    dc_sum = (OUT_W+2)'(s_d) - (OUT_W+2)'(dc_x[s_ch]) + (OUT_W+2)'(dc_y[s_ch])
           - ((OUT_W+2)'(dc_y[s_ch]) >>> 8);
    dc_out = dc_sum[OUT_W-1:0];
    if (dc_sum > DC_MAX)      dc_out = DC_MAX[OUT_W-1:0];
    else if (dc_sum < DC_MIN) dc_out = DC_MIN[OUT_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      s_v <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dc_x[i] <= '0;
        dc_y[i] <= '0;
      end
    end else begin
      s_v <= emit;
      if (emit) begin
        s_d  <= sat_d;
        s_ch <= sel_r;
      end
      if (s_v) begin
        dc_x[s_ch] <= s_d;
        dc_y[s_ch] <= dc_out;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_o  <= '0;
      ch_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= s_v & en;
      if (s_v) begin
        data_o <= dc_out;
        ch_o   <= s_ch;
      end
    end
  end
`else
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_o  <= '0;
      ch_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= emit & en;
      if (emit) begin
        data_o <= sat_d;
        ch_o   <= sel_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Directed bench for pdm_mic_frontend at default parameters: warm-up, saturation, L/R tagging,
// mono-right, mid-frame mode switch and reset/disable behaviour.
module tb_pdm_mic_frontend;
  logic              sys_clk = 1'b0;
  logic              sys_rst, en, pdm_i;
  logic [1:0]        mode;
  logic              mic_clk_o, sel_lr_o, ch_o, valid_o;
  logic signed [15:0] data_o;

  pdm_mic_frontend dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .mode     (mode),
    .pdm_i    (pdm_i),
    .mic_clk_o(mic_clk_o),
    .sel_lr_o (sel_lr_o),
    .data_o   (data_o),
    .ch_o     (ch_o),
    .valid_o  (valid_o)
  );

  always #5 sys_clk = ~sys_clk;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   pat = 1;
  int   n_l = 0, n_r = 0;
  logic mic_prev = 1'b0;
  logic tog = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // pat: 0 constant 0, 1 constant 1, 2 follow mic clock (L=1, R=0), 3 toggle once per mic period
  always @(negedge sys_clk) begin
    if (valid_o === 1'b1) begin
      if (ch_o) n_r = n_r + 1;
      else      n_l = n_l + 1;
    end
    if (mic_clk_o && !mic_prev) tog = ~tog;
    case (pat)
      0:       pdm_i = 1'b0;
      1:       pdm_i = 1'b1;
      2:       pdm_i = mic_clk_o;
      default: pdm_i = tog;
    endcase
    mic_prev = mic_clk_o;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int at, output logic c, output logic signed [15:0] d);
    at = -100000;
    c  = 1'bx;
    d  = 'x;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (valid_o === 1'b1) begin
        at = cyc;
        c  = ch_o;
        d  = data_o;
        return;
      end
    end
  endtask

  // Returns the cycle stamp of the first cycle after en was sampled high (div = 0 there).
  task automatic en_start(output int s);
    en = 1'b1;
    @(negedge sys_clk);
    s = cyc;
  endtask

  task automatic restart(input int p, input logic [1:0] m, output int s);
    en   = 1'b0;
    pat  = p;
    mode = m;
    repeat (4) @(negedge sys_clk);
    en_start(s);
  endtask

  int   s, at, at2, hi, snap;
  logic c, m0, m8, m16;
  logic signed [15:0] d;

  initial begin
    sys_rst = 1'b1;
    en      = 1'b0;
    mode    = 2'b00;
    repeat (3) @(negedge sys_clk);
    chk("rst_mic", mic_clk_o, 0);
    chk("rst_sel", sel_lr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ch", ch_o, 0);
    chk("rst_valid", valid_o, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // stereo, constant 1
    restart(1, 2'b10, s);
    hi = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge sys_clk);
      if (k < 16 && mic_clk_o) hi++;
      if (k == 0)  m0  = mic_clk_o;
      if (k == 8)  m8  = mic_clk_o;
      if (k == 16) m16 = mic_clk_o;
    end
    chk("mic_high_cycles", hi, 8);
    chk("mic_k0", m0, 1);
    chk("mic_k8", m8, 0);
    chk("mic_k16", m16, 1);
    wait_valid(5000, at, c, d);
    chk("st1_first_lat", at - s, 4097);
    chk("st1_l_ch", c, 0);
    chk("st1_l_data", d, 32767);
    wait_valid(1, at2, c, d);
    chk("st1_lr_gap", at2 - at, 1);
    chk("st1_r_ch", c, 1);
    chk("st1_r_data", d, 32767);
    wait_valid(1100, at2, c, d);
    chk("st1_ll_gap", at2 - at, 1024);
    chk("st1_l2_ch", c, 0);

    // stereo, constant 0
    restart(0, 2'b10, s);
    wait_valid(5000, at, c, d);
    chk("st0_lat", at - s, 4097);
    chk("st0_l_ch", c, 0);
    chk("st0_l_data", d, -32768);
    wait_valid(1, at2, c, d);
    chk("st0_r_ch", c, 1);
    chk("st0_r_data", d, -32768);

    // stereo, left ticks see 1, right ticks see 0
    restart(2, 2'b11, s);
    wait_valid(5000, at, c, d);
    chk("lr_l_ch", c, 0);
    chk("lr_l_data", d, 32767);
    wait_valid(1, at2, c, d);
    chk("lr_r_ch", c, 1);
    chk("lr_r_data", d, -32768);

    // mono right, alternating bits on right ticks
    restart(3, 2'b01, s);
    chk("mr_sel", sel_lr_o, 1);
    snap = n_l;
    wait_valid(5000, at, c, d);
    chk("mr_lat", at - s, 4097);
    chk("mr_ch", c, 1);
    chk("mr_data", d, 0);
    wait_valid(1100, at2, c, d);
    chk("mr_gap", at2 - at, 1024);
    chk("mr_ch2", c, 1);
    chk("mr_data2", d, 0);
    chk("mr_no_left", n_l - snap, 0);

    // mono left, then stereo requested mid-frame
    restart(1, 2'b00, s);
    chk("ml_sel", sel_lr_o, 0);
    wait_valid(5000, at, c, d);
    chk("ml_ch", c, 0);
    chk("ml_data", d, 32767);
    repeat (500) @(negedge sys_clk);
    mode = 2'b10;
    wait_valid(6000, at2, c, d);
    chk("sw_gap", at2 - at, 5120);
    chk("sw_l_ch", c, 0);
    chk("sw_l_data", d, 32767);
    wait_valid(1, at, c, d);
    chk("sw_lr_gap", at - at2, 1);
    chk("sw_r_ch", c, 1);
    chk("sw_r_data", d, 32767);

    // reset mid-frame while running, then disabled
    repeat (300) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("mrst_mic", mic_clk_o, 0);
    chk("mrst_sel", sel_lr_o, 0);
    chk("mrst_data", data_o, 0);
    chk("mrst_ch", ch_o, 0);
    chk("mrst_valid", valid_o, 0);
    sys_rst = 1'b0;
    en      = 1'b0;
    snap    = n_l + n_r;
    hi      = 0;
    repeat (2000) begin
      @(negedge sys_clk);
      if (mic_clk_o !== 1'b0) hi++;
    end
    chk("off_mic_high", hi, 0);
    chk("off_valid", (n_l + n_r) - snap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pdm_mic_frontend.md
Name: pdm_mic_frontend

Overview:
- Parametrised PDM MEMS microphone front-end.
- Generates the microphone bit clock from sys_clk and samples one or two PDM microphones sharing one data line: left on the high phase, right on the low phase.
- Runs a per-channel 3rd-order CIC decimator and emits scaled, saturated signed PCM samples with channel tags.
- Sits between the board microphone pins and the feature-extraction / CNN input buffering, as the stereo-capable, width- and rate-configurable generation of the mono sinc3 front-end.

Parameters:
- CLK_DIV, 16: sys_clk cycles per mic_clk_o period; even, ≥4 (50 MHz/16 = 3.125 MHz).
- DEC, 64: decimation ratio; power of two, 8..256.
- OUT_W, 16: output sample width; must satisfy 3*log2(DEC) ≥ OUT_W-1.
- ACC_W, 3*log2(DEC)+2: CIC internal width, derived; do not override.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous active-high reset.
- en  in  1  capture enable.
- mode  in  2  00 mono-left, 01 mono-right, 1x stereo.
- pdm_i  in  1  shared PDM data line.
- mic_clk_o  out  1  microphone bit clock.
- sel_lr_o  out  1  mic L/R select strap (0 = L, 1 = R).
- data_o  out  OUT_W  signed PCM sample.
- ch_o  out  1  channel of data_o (0 = L, 1 = R).
- valid_o  out  1  single-cycle sample strobe.

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge) clears the divider, integrators, comb delays, decimation counter and warm-up counter. Reset values: mic_clk_o=0, sel_lr_o=0, data_o=0, ch_o=0, valid_o=0. Reset mid-frame discards the partial frame; no output is produced from it.
- Divider counter div runs 0..CLK_DIV-1 while en=1.
  - mic_clk_o=1 for div < CLK_DIV/2, else 0.
  - en=0: div held at 0, mic_clk_o=0, integrators/combs/counters cleared, valid_o=0.
- Sampling ticks:
  - Left tick at div=CLK_DIV/2-1.
  - Right tick at div=CLK_DIV-1.
  - A tick for a channel not active in the latched mode is ignored.
  - Sampled bit maps 1→+1, 0→-1.
- Integrators: three cascaded ACC_W-bit signed accumulators per channel, updated on that channel's tick. Modular wrap-around is intentional and must not be saturated.
- Decimation counter: increments on each right tick, wrapping DEC-1→0. The wrap tick is the frame boundary.
- Mode latching: mode is latched on the cycle en rises and at each frame boundary. A mode change mid-frame takes effect at the next boundary. On a latched change, integrators/combs are cleared and warm-up restarts.
- At the frame boundary, each active channel's last-integrator value enters a three-stage comb (differential delay 1, ACC_W bits, registered).
- Scaling:
  - Comb result >>> (3*log2(DEC)-(OUT_W-1)), arithmetic shift.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output timing:
  - Mono: valid_o high 2 sys_clk cycles after the boundary tick, ch_o = latched mode[0].
  - Stereo: L on cycle +2 (ch_o=0), R on cycle +3 (ch_o=1).
  - data_o holds its value between strobes.
- Warm-up: the first 3 frames after reset, en rise or mode change produce no valid_o. Comb history is invalid during these frames.
- sel_lr_o = latched mode[0] in mono modes, 0 in stereo (mics strapped externally).
- Output rate = f_sys/(CLK_DIV*DEC) per channel (48.83 kHz at defaults).

Optional Feature:
- Macro: PDM_DC_BLOCK_EN.
- Defined: per-channel first-order DC-removal stage after saturation: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), computed at OUT_W+2 bits and re-saturated to OUT_W.
  - Adds 1 cycle of latency (mono +3, stereo +3/+4).
  - DC state cleared with the CIC.
- Undefined: the stage is absent and latency is as stated above.

Test Plan:
- Defaults, stereo, pdm_i held 1, en=1 after reset → 3 frames with no valid_o, then alternating L/R strobes with data_o=32767 (saturated); L→R spacing 1 cycle, same-channel spacing 1024 cycles; mic_clk_o period 16 cycles, 50% duty.
- pdm_i held 0 → data_o=-32768 on both channels after warm-up.
- Stereo; pdm_i=1 during left ticks, 0 during right ticks → L=32767, R=-32768, ch_o tagged correctly.
- Mode 01, alternating 1/0 on right ticks → only ch_o=1 strobes, data_o=0, sel_lr_o=1, no ch_o=0 strobes.
- Mode 00→1x switched mid-frame → switch at next boundary, 3 suppressed frames, then both channels output.
- sys_rst pulse mid-frame, then en=0 → all outputs 0 immediately, mic_clk_o stays 0, no valid_o while en=0.
